synapse_weight_bank: RTL and testbench

//  Parametrised byte-lane synaptic weight store for one neuron core. Holds DEPTH

---
 rtl/synapse_weight_bank_if.sv | 31 +++
 rtl/synapse_weight_bank.sv | 96 +++++++++
 tb/tb_synapse_weight_bank.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/synapse_weight_bank_if.sv
// synapse_weight_bank_if: load/read/update bus between a neuron core and its weight bank
//   master drives: kill, load_en, load_data, rd_en, rd_addr, upd_en, upd_addr, upd_delta
//   slave drives : load_done, rd_valid, rd_weight, upd_ready, addr_err
interface synapse_weight_bank_if #(
  parameter int WEIGHT_W = 8,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int DELTA_W  = 8
);
  logic                kill;
  logic                load_en;
  logic [WORD_W-1:0]   load_data;
  logic                load_done;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_valid;
  logic [WEIGHT_W-1:0] rd_weight;
  logic                upd_en;
  logic [ADDR_W-1:0]   upd_addr;
  logic [DELTA_W-1:0]  upd_delta;
  logic                upd_ready;
  logic                addr_err;
  modport master (
    output kill, load_en, load_data, rd_en, rd_addr, upd_en, upd_addr, upd_delta,
    input  load_done, rd_valid, rd_weight, upd_ready, addr_err
  );
  modport slave (
    input  kill, load_en, load_data, rd_en, rd_addr, upd_en, upd_addr, upd_delta,
    output load_done, rd_valid, rd_weight, upd_ready, addr_err
  );
endinterface

// File: rtl/synapse_weight_bank.sv
// synapse_weight_bank: byte-lane synaptic weight table with bulk load, 1-cycle reads and saturating STDP updates
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : synapse_weight_bank_if.slave (load, read, update and error signals)
module synapse_weight_bank #(
  parameter int WEIGHT_W = 8,
  parameter int WORD_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 16,
  parameter int DELTA_W  = 8
) (
  input logic                  clk,
  input logic                  rst,
  synapse_weight_bank_if.slave bus
);
  localparam int LANES  = WORD_W / WEIGHT_W;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SUM_W  = WEIGHT_W + DELTA_W + 1;
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_UPD_RD, S_UPD_WR} state_t;
  state_t r_state, w_next;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [IDX_W-1:0]    r_load_cnt, r_upd_idx;
  logic [LANE_W-1:0]   r_upd_lane;
  logic [DELTA_W-1:0]  r_delta;
  logic [WORD_W-1:0]   r_word;
  logic                r_rd_valid, r_addr_err;
  logic [WEIGHT_W-1:0] r_rd_weight;
  logic [ADDR_W-1:0]   w_rd_wa, w_upd_wa;
  logic [LANE_W-1:0]   w_rd_lane, w_upd_lane;
  logic                w_rd_oor, w_upd_oor, w_rd_acc, w_upd_acc, w_upd_go, w_load_wr, w_upd_wr, w_bypass;
  logic [WEIGHT_W-1:0] w_old, w_new_w, w_rd_val;
  logic [SUM_W-1:0]    w_sum;
  logic [WORD_W-1:0]   w_new_word, w_rd_data;
  assign w_rd_wa    = bus.rd_addr / ADDR_W'(LANES);
  assign w_rd_lane  = LANE_W'(bus.rd_addr % ADDR_W'(LANES));
  assign w_rd_oor   = w_rd_wa >= ADDR_W'(DEPTH);
  assign w_upd_wa   = bus.upd_addr / ADDR_W'(LANES);
  assign w_upd_lane = LANE_W'(bus.upd_addr % ADDR_W'(LANES));
  assign w_upd_oor  = w_upd_wa >= ADDR_W'(DEPTH);
  // kill outranks every request issued in the same cycle
  assign w_rd_acc  = bus.rd_en && !bus.kill && r_state != S_LOAD;
  assign w_upd_acc = bus.upd_en && !bus.kill && r_state == S_RUN;
  assign w_upd_go  = w_upd_acc && !w_upd_oor;
  assign w_load_wr = bus.load_en && !bus.kill && r_state == S_LOAD;
  assign w_upd_wr  = !bus.kill && r_state == S_UPD_WR;
  // unsigned weight plus sign-extended delta, wide enough that neither end can wrap
  assign w_old   = r_word[r_upd_lane*WEIGHT_W +: WEIGHT_W];
  assign w_sum   = {{(DELTA_W+1){1'b0}}, w_old} + {{(WEIGHT_W+1){r_delta[DELTA_W-1]}}, r_delta};
  assign w_new_w = w_sum[SUM_W-1] ? '0 : (|w_sum[SUM_W-2:WEIGHT_W]) ? '1 : w_sum[WEIGHT_W-1:0];
  always_comb begin
    w_new_word = r_word;
    w_new_word[r_upd_lane*WEIGHT_W +: WEIGHT_W] = w_new_w;
  end
  // a read of the word being written back sees the merged word, not the stale array copy
  assign w_bypass  = r_state == S_UPD_WR && IDX_W'(w_rd_wa) == r_upd_idx;
  assign w_rd_data = w_bypass ? w_new_word : r_mem[IDX_W'(w_rd_wa)];
  assign w_rd_val  = w_rd_data[w_rd_lane*WEIGHT_W +: WEIGHT_W];
  always_comb begin
    w_next        = bus.kill ? S_LOAD :
                    r_state == S_LOAD   ? ((w_load_wr && r_load_cnt == IDX_W'(DEPTH-1)) ? S_RUN : S_LOAD) :
                    r_state == S_RUN    ? (w_upd_go ? S_UPD_RD : S_RUN) :
                    r_state == S_UPD_RD ? S_UPD_WR : S_RUN;
    bus.upd_ready = r_state == S_RUN;
    bus.load_done = r_state != S_LOAD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_LOAD;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_load_cnt  <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_weight <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_load_cnt <= bus.kill ? '0 : w_load_wr ? r_load_cnt + IDX_W'(1) : r_load_cnt;
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_weight <= w_rd_oor ? '0 : w_rd_val;
      r_addr_err <= (w_rd_acc && w_rd_oor) || (w_upd_acc && w_upd_oor);
    end
  // table contents survive reset and kill; only the control state is cleared
  always_ff @(posedge clk) begin
    if (w_load_wr) r_mem[r_load_cnt] <= bus.load_data;
    if (w_upd_wr) r_mem[r_upd_idx] <= w_new_word;
    if (w_upd_go) begin
      r_upd_idx  <= IDX_W'(w_upd_wa);
      r_upd_lane <= w_upd_lane;
      r_delta    <= bus.upd_delta;
    end
    if (r_state == S_UPD_RD) r_word <= r_mem[r_upd_idx];
  end
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_weight = r_rd_weight;
  assign bus.addr_err  = r_addr_err;
endmodule

// File: tb/tb_synapse_weight_bank.sv
// tb_synapse_weight_bank: randomized self-checking bench against a per-weight byte model
module tb_synapse_weight_bank;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [7:0] wt [128];
  synapse_weight_bank_if bus ();
  synapse_weight_bank dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout required finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] sat(input logic [7:0] o, input logic [7:0] d);
    int n;
    n = int'(o) + int'($signed(d));
    return n < 0 ? 8'd0 : n > 255 ? 8'd255 : 8'(n);
  endfunction
  task automatic fill_model(input bit rnd);
    for (int i = 0; i < 128; i++) wt[i] = rnd ? 8'($urandom) : 8'(i);
  endtask
  task automatic load_words(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bus.load_en = 1'b1;
      bus.load_data = {wt[4*i+3], wt[4*i+2], wt[4*i+1], wt[4*i]};
      tick;
    end
    bus.load_en = 1'b0;
  endtask
  task automatic rd(input int a, output logic [7:0] w, output logic v, output logic e);
    bus.rd_en = 1'b1;
    bus.rd_addr = 16'(a);
    tick;
    bus.rd_en = 1'b0;
    w = bus.rd_weight;
    v = bus.rd_valid;
    e = bus.addr_err;
  endtask
  task automatic upd(input int a, input logic [7:0] d);
    bus.upd_en = 1'b1;
    bus.upd_addr = 16'(a);
    bus.upd_delta = d;
    tick;
    bus.upd_en = 1'b0;
    tick;
    tick;
    wt[a] = sat(wt[a], d);
  endtask
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick;
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b required 0", bus.load_done); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b required 0", bus.rd_valid); end
    checks++; if (bus.rd_weight !== 8'h00) begin errors++; $display("FAIL reset_rd_weight got %h required 00", bus.rd_weight); end
    checks++; if (bus.upd_ready !== 1'b0) begin errors++; $display("FAIL reset_upd_ready got %b required 0", bus.upd_ready); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b required 0", bus.addr_err); end
    rst = 1'b1;
    tick;
  endtask
  task automatic test_load;
    logic [7:0] w;
    logic v, e;
    fill_model(1'b0);
    load_words(0, 31);
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL load_done_early got %b required 0", bus.load_done); end
    rd(3, w, v, e);
    checks++; if (v !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL load_read_ignored got v=%b e=%b required v=0 e=0", v, e); end
    load_words(31, 1);
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL load_done_rise got %b required 1", bus.load_done); end
    rd(5, w, v, e);
    checks++; if (w !== 8'h05 || v !== 1'b1) begin errors++; $display("FAIL read5 got %h/%b required 05/1", w, v); end
    rd(127, w, v, e);
    checks++; if (w !== 8'h7F || e !== 1'b0) begin errors++; $display("FAIL read127 got %h/%b required 7f/0", w, e); end
  endtask
  task automatic test_saturate;
    logic [7:0] w;
    logic v, e;
    rd(10, w, v, e);
    checks++; if (w !== wt[10]) begin errors++; $display("FAIL sat_initial got %h required %h", w, wt[10]); end
    upd(10, 8'h7F);
    rd(10, w, v, e);
    checks++; if (w !== wt[10]) begin errors++; $display("FAIL sat_add got %h required %h", w, wt[10]); end
    upd(10, 8'h7F);
    rd(10, w, v, e);
    checks++; if (w !== wt[10]) begin errors++; $display("FAIL sat_high got %h required %h", w, wt[10]); end
    upd(10, 8'h80);
    rd(10, w, v, e);
    checks++; if (w !== wt[10]) begin errors++; $display("FAIL sat_sub got %h required %h", w, wt[10]); end
    for (int a = 8; a < 12; a++) begin
      rd(a, w, v, e);
      checks++; if (w !== wt[a]) begin errors++; $display("FAIL sat_lane%0d got %h required %h", a, w, wt[a]); end
    end
  endtask
  task automatic test_floor_ready;
    logic [7:0] w;
    logic v, e;
    int low;
    low = 0;
    checks++; if (bus.upd_ready !== 1'b1) begin errors++; $display("FAIL ready_idle got %b required 1", bus.upd_ready); end
    bus.upd_en = 1'b1;
    bus.upd_addr = 16'd0;
    bus.upd_delta = 8'hFF;
    tick;
    bus.upd_en = 1'b0;
    for (int i = 0; i < 10 && bus.upd_ready !== 1'b1; i++) begin
      low++;
      tick;
    end
    wt[0] = sat(wt[0], 8'hFF);
    checks++; if (low !== 2) begin errors++; $display("FAIL ready_low_cycles got %0d required 2", low); end
    rd(0, w, v, e);
    checks++; if (w !== wt[0]) begin errors++; $display("FAIL floor got %h required %h", w, wt[0]); end
  endtask
  task automatic test_oor;
    logic [7:0] w;
    logic v, e;
    rd(128, w, v, e);
    checks++; if (w !== 8'h00 || v !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL oor_read got w=%h v=%b e=%b required 00 1 1", w, v, e); end
    tick;
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL oor_pulse got %b required 0", bus.addr_err); end
    bus.upd_en = 1'b1;
    bus.upd_addr = 16'd200;
    bus.upd_delta = 8'h11;
    tick;
    bus.upd_en = 1'b0;
    checks++; if (bus.addr_err !== 1'b1 || bus.upd_ready !== 1'b1) begin errors++; $display("FAIL oor_upd got err=%b rdy=%b required 1 1", bus.addr_err, bus.upd_ready); end
    tick;
    for (int a = 0; a < 128; a++) begin
      rd(a, w, v, e);
      checks++; if (w !== wt[a]) begin errors++; $display("FAIL oor_table%0d got %h required %h", a, w, wt[a]); end
    end
  endtask
  task automatic test_bypass;
    for (int k = 0; k < 2; k++) begin
      int ra;
      logic [7:0] pre;
      ra = 6 + k;
      pre = wt[6];
      bus.upd_en = 1'b1;
      bus.upd_addr = 16'd6;
      bus.upd_delta = 8'h01;
      bus.rd_en = 1'b1;
      bus.rd_addr = 16'd6;
      tick;
      bus.upd_en = 1'b0;
      bus.rd_en = 1'b0;
      checks++; if (bus.rd_weight !== pre) begin errors++; $display("FAIL same_cycle_read got %h required %h", bus.rd_weight, pre); end
      wt[6] = sat(wt[6], 8'h01);
      tick;
      bus.rd_en = 1'b1;
      bus.rd_addr = 16'(ra);
      tick;
      bus.rd_en = 1'b0;
      checks++; if (bus.rd_weight !== wt[ra] || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL bypass_addr%0d got %h required %h", ra, bus.rd_weight, wt[ra]); end
    end
  endtask
  task automatic test_kill;
    logic [7:0] w;
    logic v, e;
    bus.upd_en = 1'b1;
    bus.upd_addr = 16'd20;
    bus.upd_delta = 8'h05;
    tick;
    bus.upd_en = 1'b0;
    bus.kill = 1'b1;
    tick;
    bus.kill = 1'b0;
    checks++; if (bus.load_done !== 1'b0 || bus.upd_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL kill_state got done=%b rdy=%b vld=%b required 0 0 0", bus.load_done, bus.upd_ready, bus.rd_valid); end
    tick;
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL kill_stays_load got %b required 0", bus.load_done); end
    fill_model(1'b1);
    load_words(0, 32);
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL kill_reload got %b required 1", bus.load_done); end
    for (int i = 0; i < 16; i++) begin
      int a;
      a = $urandom_range(127);
      rd(a, w, v, e);
      checks++; if (w !== wt[a]) begin errors++; $display("FAIL kill_read%0d got %h required %h", a, w, wt[a]); end
    end
    fill_model(1'b1);
    load_words(0, 17);
    rst = 1'b0;
    #3;
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rst_async got %b required 0", bus.load_done); end
    rst = 1'b1;
    fill_model(1'b1);
    load_words(0, 31);
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rst_cnt_restart got %b required 0", bus.load_done); end
    load_words(31, 1);
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL rst_reload got %b required 1", bus.load_done); end
    for (int a = 0; a < 128; a++) begin
      rd(a, w, v, e);
      checks++; if (w !== wt[a]) begin errors++; $display("FAIL rst_table%0d got %h required %h", a, w, wt[a]); end
    end
  endtask
  task automatic test_random;
    logic [7:0] w;
    logic v, e;
    for (int it = 0; it < 150; it++) begin
      int ta, a0, a1, a2;
      logic [7:0] d, e0, e1;
      ta = $urandom_range(127);
      a0 = $urandom_range(127);
      a1 = $urandom_range(127);
      a2 = $urandom_range(1) ? (ta & ~3) + $urandom_range(3) : $urandom_range(127);
      d = 8'($urandom);
      if ($urandom_range(3) == 0) begin
        rd(a0, w, v, e);
        checks++; if (w !== wt[a0] || v !== 1'b1) begin errors++; $display("FAIL rnd_read%0d got %h required %h", a0, w, wt[a0]); end
        continue;
      end
      checks++; if (bus.upd_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready got %b required 1", bus.upd_ready); end
      e0 = wt[a0];
      e1 = wt[a1];
      wt[ta] = sat(wt[ta], d);
      bus.upd_en = 1'b1;
      bus.upd_addr = 16'(ta);
      bus.upd_delta = d;
      bus.rd_en = 1'b1;
      bus.rd_addr = 16'(a0);
      tick;
      bus.upd_en = 1'b0;
      checks++; if (bus.rd_weight !== e0) begin errors++; $display("FAIL rnd_req_read%0d got %h required %h", a0, bus.rd_weight, e0); end
      bus.rd_addr = 16'(a1);
      tick;
      checks++; if (bus.rd_weight !== e1) begin errors++; $display("FAIL rnd_updrd_read%0d got %h required %h", a1, bus.rd_weight, e1); end
      bus.rd_addr = 16'(a2);
      tick;
      bus.rd_en = 1'b0;
      checks++; if (bus.rd_weight !== wt[a2]) begin errors++; $display("FAIL rnd_updwr_read%0d got %h required %h", a2, bus.rd_weight, wt[a2]); end
    end
    for (int a = 0; a < 128; a++) begin
      rd(a, w, v, e);
      checks++; if (w !== wt[a]) begin errors++; $display("FAIL rnd_table%0d got %h required %h", a, w, wt[a]); end
    end
  endtask
  initial begin
    rst = 1'b0;
    bus.kill = 1'b0;
    bus.load_en = 1'b0;
    bus.load_data = '0;
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
    bus.upd_en = 1'b0;
    bus.upd_addr = '0;
    bus.upd_delta = '0;
    test_reset;
    test_load;
    test_saturate;
    test_floor_ready;
    test_oor;
    test_bypass;
    test_kill;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
